// File: rtl/bulls_cows_game_ctrl_if.sv
// bulls_cows_game_ctrl_if: guess/secret handshake, scorer link and status outputs of the game controller
interface bulls_cows_game_ctrl_if #(parameter int TRY_W = 4);
  logic [7:0] secret_in;
  logic secret_load;
  logic [7:0] guess_in;
  logic guess_valid;
  logic guess_ready;
  logic [7:0] s_out;
  logic [7:0] g_out;
  logic [1:0] bulls_in;
  logic [1:0] cows_in;
  logic result_valid;
  logic [1:0] result_bulls;
  logic [1:0] result_cows;
  logic guess_err;
  logic secret_err;
  logic [TRY_W-1:0] tries;
  logic win;
  logic lose;
  modport master (
    output secret_in, secret_load, guess_in, guess_valid, bulls_in, cows_in,
    input guess_ready, s_out, g_out, result_valid, result_bulls, result_cows,
    input guess_err, secret_err, tries, win, lose
  );
  modport slave (
    input secret_in, secret_load, guess_in, guess_valid, bulls_in, cows_in,
    output guess_ready, s_out, g_out, result_valid, result_bulls, result_cows,
    output guess_err, secret_err, tries, win, lose
  );
endinterface

// File: rtl/bulls_cows_game_ctrl.sv
// bulls_cows_game_ctrl: holds secret/guess for the scorer, validates digits, counts tries, declares win/lose
module bulls_cows_game_ctrl #(
  parameter int MAX_TRIES = 8,
  parameter int TRY_W = 4
) (
  input logic clk,
  input logic rst,
  bulls_cows_game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARMED, SCORE, WIN, LOSE} state_t;
  state_t r_state, w_next;
  logic [7:0] r_s, r_g;
  logic [TRY_W-1:0] r_tries, w_tries_inc;
  logic [1:0] r_bulls, r_cows;
  logic r_result_valid, r_guess_err, r_secret_err;
  logic w_secret_ok, w_guess_ok, w_accept;
  function automatic logic digits_ok(input logic [7:0] d);
    return d[3:0] <= 4'd9 && d[7:4] <= 4'd9 && d[3:0] != d[7:4];
  endfunction
  assign w_secret_ok = digits_ok(bus.secret_in);
  assign w_guess_ok = digits_ok(bus.guess_in);
  assign w_accept = r_state == ARMED && bus.guess_valid;
  assign w_tries_inc = r_tries + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // a rejected load still aborts a pending score so it is never reported
  always_comb
    w_next = bus.secret_load ? ((w_secret_ok || r_state == SCORE) ? ARMED : r_state)
           : r_state == ARMED ? ((bus.guess_valid && w_guess_ok) ? SCORE : ARMED)
           : r_state == SCORE ? (bus.bulls_in == 2'd2 ? WIN
                                : w_tries_inc == TRY_W'(MAX_TRIES) ? LOSE : ARMED)
           : r_state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s <= '0;
      r_g <= '0;
      r_tries <= '0;
      r_bulls <= '0;
      r_cows <= '0;
      r_result_valid <= 1'b0;
      r_guess_err <= 1'b0;
      r_secret_err <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_guess_err <= 1'b0;
      r_secret_err <= 1'b0;
      if (bus.secret_load) begin
        if (w_secret_ok) begin
          r_s <= bus.secret_in;
          r_g <= '0;
          r_tries <= '0;
          r_bulls <= '0;
          r_cows <= '0;
        end else r_secret_err <= 1'b1;
      end else if (w_accept) begin
        if (w_guess_ok) r_g <= bus.guess_in;
        else r_guess_err <= 1'b1;
      end else if (r_state == SCORE) begin
        r_bulls <= bus.bulls_in;
        r_cows <= bus.cows_in;
        r_result_valid <= 1'b1;
        r_tries <= w_tries_inc;
      end
    end
  assign bus.guess_ready = r_state == ARMED;
  assign bus.s_out = r_s;
  assign bus.g_out = r_g;
  assign bus.result_valid = r_result_valid;
  assign bus.result_bulls = r_bulls;
  assign bus.result_cows = r_cows;
  assign bus.guess_err = r_guess_err;
  assign bus.secret_err = r_secret_err;
  assign bus.tries = r_tries;
  assign bus.win = r_state == WIN;
  assign bus.lose = r_state == LOSE;
endmodule

// File: tb/tb_bulls_cows_game_ctrl.sv
// tb_bulls_cows_game_ctrl: directed scenarios for the game controller with a behavioural scorer
module tb_bulls_cows_game_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bulls_cows_game_ctrl_if bus ();
  bulls_cows_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.bulls_in = {1'b0, bus.s_out[3:0] == bus.g_out[3:0]} + {1'b0, bus.s_out[7:4] == bus.g_out[7:4]};
  assign bus.cows_in = {1'b0, bus.s_out[3:0] == bus.g_out[7:4]} + {1'b0, bus.s_out[7:4] == bus.g_out[3:0]};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [7:0] v);
    bus.secret_in = v;
    bus.secret_load = 1'b1;
    tick();
    bus.secret_load = 1'b0;
  endtask
  task automatic guess(input logic [7:0] v);
    bus.guess_in = v;
    bus.guess_valid = 1'b1;
    tick();
    bus.guess_valid = 1'b0;
  endtask
  task automatic test_reset;
    logic [31:0] got;
    tick();
    rst = 1'b0;
    load(8'h37);
    guess(8'h12);
    rst = 1'b1;
    #1;
    got = {bus.s_out, bus.g_out, bus.tries, bus.result_bulls, bus.result_cows,
           bus.result_valid, bus.guess_err, bus.secret_err, bus.win, bus.lose, bus.guess_ready};
    checks++;
    if (got !== 32'h0) begin errors++; $display("FAIL reset_mid_score got %h exp 0", got); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_no_result got %b exp 0", bus.result_valid); end
    load(8'h37);
    got = {16'h0, bus.s_out, bus.guess_ready, bus.tries, 3'b0};
    checks++;
    if (got !== {16'h0, 8'h37, 1'b1, 4'd0, 3'b0}) begin errors++; $display("FAIL reset_load got %h exp s=37 rdy=1 tries=0", got); end
  endtask
  task automatic test_exact;
    load(8'h37);
    guess(8'h37);
    checks++;
    if ({bus.g_out, bus.guess_ready, bus.result_valid} !== {8'h37, 1'b0, 1'b0}) begin
      errors++; $display("FAIL exact_score_cycle got g=%h rdy=%b rv=%b exp g=37 rdy=0 rv=0", bus.g_out, bus.guess_ready, bus.result_valid);
    end
    tick();
    checks++;
    if ({bus.result_valid, bus.result_bulls, bus.result_cows, bus.tries, bus.win, bus.lose} !== {1'b1, 2'd2, 2'd0, 4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL exact_result got rv=%b b=%0d c=%0d t=%0d w=%b l=%b exp 1 2 0 1 1 0",
                         bus.result_valid, bus.result_bulls, bus.result_cows, bus.tries, bus.win, bus.lose);
    end
    guess(8'h12);
    tick();
    checks++;
    if ({bus.g_out, bus.guess_err, bus.guess_ready, bus.win, bus.result_valid, bus.tries} !== {8'h37, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1}) begin
      errors++; $display("FAIL exact_ignore_in_win got g=%h err=%b rdy=%b w=%b rv=%b t=%0d", bus.g_out, bus.guess_err, bus.guess_ready, bus.win, bus.result_valid, bus.tries);
    end
  endtask
  task automatic test_partial;
    logic [7:0] g [4] = '{8'h73, 8'h38, 8'h17, 8'h71};
    logic [1:0] b [4] = '{2'd0, 2'd1, 2'd1, 2'd0};
    logic [1:0] c [4] = '{2'd2, 2'd0, 2'd0, 2'd1};
    load(8'h37);
    for (int i = 0; i < 4; i++) begin
      guess(g[i]);
      tick();
      checks++;
      if ({bus.result_valid, bus.result_bulls, bus.result_cows, bus.tries, bus.win} !== {1'b1, b[i], c[i], 4'(i + 1), 1'b0}) begin
        errors++; $display("FAIL partial_%h got rv=%b b=%0d c=%0d t=%0d w=%b exp b=%0d c=%0d t=%0d",
                           g[i], bus.result_valid, bus.result_bulls, bus.result_cows, bus.tries, bus.win, b[i], c[i], i + 1);
      end
    end
    checks++;
    if ({bus.tries, bus.guess_ready, bus.lose} !== {4'd4, 1'b1, 1'b0}) begin
      errors++; $display("FAIL partial_end got t=%0d rdy=%b l=%b exp 4 1 0", bus.tries, bus.guess_ready, bus.lose);
    end
  endtask
  task automatic test_invalid;
    guess(8'h33);
    checks++;
    if ({bus.guess_err, bus.result_valid, bus.tries, bus.guess_ready, bus.g_out} !== {1'b1, 1'b0, 4'd4, 1'b1, 8'h71}) begin
      errors++; $display("FAIL invalid_33 got err=%b rv=%b t=%0d rdy=%b g=%h exp 1 0 4 1 71", bus.guess_err, bus.result_valid, bus.tries, bus.guess_ready, bus.g_out);
    end
    tick();
    checks++;
    if ({bus.guess_err, bus.result_valid} !== 2'b00) begin errors++; $display("FAIL invalid_pulse_width got err=%b rv=%b exp 0 0", bus.guess_err, bus.result_valid); end
    guess(8'hA2);
    checks++;
    if ({bus.guess_err, bus.g_out} !== {1'b1, 8'h71}) begin errors++; $display("FAIL invalid_A2 got err=%b g=%h exp 1 71", bus.guess_err, bus.g_out); end
    guess(8'h98);
    checks++;
    if ({bus.guess_err, bus.g_out, bus.guess_ready} !== {1'b0, 8'h98, 1'b0}) begin errors++; $display("FAIL invalid_98_accepted got err=%b g=%h rdy=%b exp 0 98 0", bus.guess_err, bus.g_out, bus.guess_ready); end
    tick();
    load(8'h55);
    checks++;
    if ({bus.secret_err, bus.s_out, bus.guess_ready, bus.tries} !== {1'b1, 8'h37, 1'b1, 4'd5}) begin
      errors++; $display("FAIL invalid_secret_armed got err=%b s=%h rdy=%b t=%0d exp 1 37 1 5", bus.secret_err, bus.s_out, bus.guess_ready, bus.tries);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load(8'h55);
    checks++;
    if ({bus.secret_err, bus.s_out, bus.guess_ready} !== {1'b1, 8'h00, 1'b0}) begin
      errors++; $display("FAIL invalid_secret_idle got err=%b s=%h rdy=%b exp 1 00 0", bus.secret_err, bus.s_out, bus.guess_ready);
    end
    guess(8'h12);
    checks++;
    if ({bus.secret_err, bus.guess_err, bus.g_out, bus.guess_ready} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++; $display("FAIL idle_ignore got serr=%b gerr=%b g=%h rdy=%b exp 0 0 00 0", bus.secret_err, bus.guess_err, bus.g_out, bus.guess_ready);
    end
  endtask
  task automatic test_lose;
    load(8'h37);
    for (int i = 0; i < 8; i++) begin
      guess(8'h12);
      tick();
      checks++;
      if ({bus.result_valid, bus.result_bulls, bus.result_cows, bus.tries, bus.lose, bus.guess_ready, bus.win} !==
          {1'b1, 2'd0, 2'd0, 4'(i + 1), i == 7, i != 7, 1'b0}) begin
        errors++; $display("FAIL lose_try%0d got rv=%b b=%0d c=%0d t=%0d l=%b rdy=%b w=%b", i + 1,
                           bus.result_valid, bus.result_bulls, bus.result_cows, bus.tries, bus.lose, bus.guess_ready, bus.win);
      end
    end
    guess(8'h12);
    tick();
    checks++;
    if ({bus.tries, bus.lose, bus.guess_err, bus.result_valid} !== {4'd8, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL lose_hold got t=%0d l=%b err=%b rv=%b exp 8 1 0 0", bus.tries, bus.lose, bus.guess_err, bus.result_valid);
    end
    load(8'h45);
    checks++;
    if ({bus.tries, bus.lose, bus.guess_ready, bus.s_out} !== {4'd0, 1'b0, 1'b1, 8'h45}) begin
      errors++; $display("FAIL lose_reload got t=%0d l=%b rdy=%b s=%h exp 0 0 1 45", bus.tries, bus.lose, bus.guess_ready, bus.s_out);
    end
  endtask
  task automatic test_back_to_back;
    load(8'h37);
    guess(8'h12);
    tick();
    guess(8'h73);
    checks++;
    if ({bus.result_valid, bus.g_out, bus.guess_ready} !== {1'b0, 8'h73, 1'b0}) begin
      errors++; $display("FAIL b2b_accept got rv=%b g=%h rdy=%b exp 0 73 0", bus.result_valid, bus.g_out, bus.guess_ready);
    end
    tick();
    checks++;
    if ({bus.result_valid, bus.result_cows, bus.tries} !== {1'b1, 2'd2, 4'd2}) begin
      errors++; $display("FAIL b2b_result got rv=%b c=%0d t=%0d exp 1 2 2", bus.result_valid, bus.result_cows, bus.tries);
    end
  endtask
  task automatic test_simultaneous;
    load(8'h37);
    bus.secret_in = 8'h45;
    bus.secret_load = 1'b1;
    bus.guess_in = 8'h12;
    bus.guess_valid = 1'b1;
    tick();
    bus.secret_load = 1'b0;
    bus.guess_valid = 1'b0;
    checks++;
    if ({bus.s_out, bus.g_out, bus.guess_ready, bus.guess_err} !== {8'h45, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL simul_load_guess got s=%h g=%h rdy=%b err=%b exp 45 00 1 0", bus.s_out, bus.g_out, bus.guess_ready, bus.guess_err);
    end
    tick();
    checks++;
    if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL simul_no_result got %b exp 0", bus.result_valid); end
    guess(8'h12);
    tick();
    guess(8'h13);
    load(8'h55);
    checks++;
    if ({bus.secret_err, bus.result_valid, bus.tries, bus.guess_ready, bus.s_out} !== {1'b1, 1'b0, 4'd1, 1'b1, 8'h45}) begin
      errors++; $display("FAIL simul_bad_load_score got err=%b rv=%b t=%0d rdy=%b s=%h exp 1 0 1 1 45", bus.secret_err, bus.result_valid, bus.tries, bus.guess_ready, bus.s_out);
    end
    guess(8'h13);
    load(8'h37);
    checks++;
    if ({bus.result_valid, bus.tries, bus.guess_ready, bus.s_out, bus.result_bulls} !== {1'b0, 4'd0, 1'b1, 8'h37, 2'd0}) begin
      errors++; $display("FAIL simul_load_score got rv=%b t=%0d rdy=%b s=%h b=%0d exp 0 0 1 37 0", bus.result_valid, bus.tries, bus.guess_ready, bus.s_out, bus.result_bulls);
    end
    tick();
    checks++;
    if ({bus.result_valid, bus.tries} !== {1'b0, 4'd0}) begin errors++; $display("FAIL simul_after got rv=%b t=%0d exp 0 0", bus.result_valid, bus.tries); end
  endtask
  initial begin
    bus.secret_in = '0;
    bus.secret_load = 1'b0;
    bus.guess_in = '0;
    bus.guess_valid = 1'b0;
    test_reset();
    test_exact();
    test_partial();
    test_invalid();
    test_lose();
    test_back_to_back();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bulls_cows_game_ctrl.md
# bulls_cows_game_ctrl

Sequential game controller for the 2-digit bulls-and-cows game. It holds the registered secret and guess that drive the combinational scorer's `s`/`g` inputs, and consumes the scorer's `bulls`/`cows` outputs. On top of that it validates digits, counts attempts, and declares win or lose. It sits directly downstream of the scorer and upstream of display/LED logic.

## Interface
- `MAX_TRIES`, default 8: scored guesses allowed before lose; range 1..2^TRY_W-1.
- `TRY_W`, default 4: width of the try counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `secret_in`  in  8  secret; [3:0] digit 0, [7:4] digit 1, each BCD.
- `secret_load`  in  1  one-cycle strobe; loads `secret_in` and restarts the game.
- `guess_in`  in  8  guess, same packing as `secret_in`.
- `guess_valid`  in  1  guess offered; accepted only when `guess_ready`=1.
- `guess_ready`  out  1  high in ARMED only.
- `s_out`  out  8  registered secret, wired to scorer `s`.
- `g_out`  out  8  registered guess, wired to scorer `g`.
- `bulls_in`  in  2  from scorer `bulls`.
- `cows_in`  in  2  from scorer `cows`.
- `result_valid`  out  1  one-cycle pulse; result fields valid.
- `result_bulls`  out  2  captured bulls.
- `result_cows`  out  2  captured cows.
- `guess_err`  out  1  one-cycle pulse; guess rejected.
- `secret_err`  out  1  one-cycle pulse; secret rejected.
- `tries`  out  TRY_W  count of scored guesses in this game.
- `win`  out  1  level; high in WIN.
- `lose`  out  1  level; high in LOSE.

## Operation
- Digit validity rule: both nibbles ≤ 9 and nibble0 ≠ nibble1.
- States:
  - IDLE: no secret loaded.
  - ARMED: waiting for a guess.
  - SCORE: one cycle while the scorer settles on the new `g_out`.
  - WIN: game won, terminal until the next load.
  - LOSE: game lost, terminal until the next load.
- `secret_load` behaviour:
  - Has priority in every state, including SCORE, and over a same-cycle `guess_valid`.
  - Valid `secret_in`: `s_out` <= `secret_in`, `g_out` <= 0, `tries` <= 0, `win`/`lose` cleared, state -> ARMED.
  - Invalid `secret_in`: `secret_err` pulses. `s_out`, `tries` and state are unchanged, except that SCORE -> ARMED and the pending score is discarded.
- ARMED with `guess_valid`:
  - Valid guess: `g_out` <= `guess_in`, state -> SCORE.
  - Invalid guess: `guess_err` pulses, `g_out` and `tries` unchanged, stay ARMED, no `result_valid`.
- SCORE, leaving the state:
  - Capture `bulls_in`/`cows_in` into `result_*` and pulse `result_valid`.
  - `tries` <= `tries`+1.
  - Next state, in priority order: `bulls_in`=2 -> WIN; else `tries`+1 = MAX_TRIES -> LOSE; else -> ARMED.
- WIN/LOSE: `guess_valid` is ignored (no ready, no error); leave only via `secret_load` or `rst`.
- IDLE: `guess_valid` is ignored.
- `tries` never wraps. It saturates at MAX_TRIES by construction, since LOSE blocks further guesses.

## Timing
- Reset (async assert, sync release): state IDLE, `s_out`=0, `g_out`=0, `tries`=0, `result_bulls`=0, `result_cows`=0. `result_valid`, `guess_err`, `secret_err`, `win`, `lose`, `guess_ready` all 0.
- Reset mid-game: everything returns to the reset values immediately; a pending SCORE result is never reported.
- Guess accepted at edge N:
  - `g_out` is updated after edge N; cycle N+1 is SCORE.
  - `result_valid`, `result_*`, the new `tries` and `win`/`lose` are visible after edge N+1.
  - Accept-to-result latency is 2 edges.
- `guess_ready` is 0 during SCORE; the next guess can be accepted at edge N+2 at the earliest.
- `result_*` hold their value until the next capture or load; a valid `secret_load` clears them to 0.
- Error pulses are registered: visible the cycle after the offending strobe, one cycle wide.
- `guess_ready` is a combinational decode of the state register.
- The scorer is combinational from `s_out`/`g_out`. The inputs `bulls_in`/`cows_in` must be stable within one clock period.

## Test plan
- **Reset and load:** assert `rst` mid-SCORE -> all outputs at reset values and no `result_valid`. Then `secret_load` with 8'h37 -> `s_out`=8'h37, `guess_ready`=1, `tries`=0.
- **Exact guess:** secret 8'h37, guess 8'h37 -> 2 edges later `result_valid`=1, bulls=2, cows=0, `tries`=1, `win`=1. A further `guess_valid` is ignored.
- **Partial matches:** secret 8'h37.
  - Guess 8'h73 -> cows=2, bulls=0.
  - Guess 8'h38 -> bulls=1.
  - Guess 8'h17 -> bulls=1 (digit 0 matches).
  - Guess 8'h71 -> cows=1.
  - After these four guesses `tries`=4, state ARMED.
- **Invalid input:**
  - Guess 8'h33 -> `guess_err` pulse, `tries` unchanged, no `result_valid`.
  - Guess 8'hA2 -> `guess_err`.
  - `secret_load` with 8'h55 from IDLE -> `secret_err`, state stays IDLE, `guess_ready`=0.
- **Lose:** MAX_TRIES=8, secret 8'h37, eight guesses of 8'h12 -> eight `result_valid` pulses with 0/0. After the 8th, `tries`=8, `lose`=1, `guess_ready`=0.
- **Simultaneous events:**
  - `secret_load` with 8'h45 in the same cycle as a valid guess in ARMED -> new secret loaded and the guess dropped.
  - `secret_load` during SCORE -> no `result_valid`, `tries`=0, ARMED.
